// File: rtl/sram_arbiter.sv
// sram_arbiter: single-port SRAM access controller shared by the recorder
// (write) stream and the player (read) stream. Each granted request becomes
// one strobe sequence: access phase (WE_N or OE_N low for a fixed number of
// cycles) followed by a one-cycle recovery phase carrying the ack/valid pulse.
// Contention in idle is resolved round-robin via a last-grant register.
//
// Handshake: i_rec_req / i_play_req are levels sampled only in S_IDLE; the
// address (and write data) must stay stable while the request is high. A
// transaction completes with a one-cycle o_rec_ack / o_play_valid pulse in
// S_RECOVER; the requester drops its request in the following cycle, and a
// request still high in S_IDLE after that is served as a new transaction.
module sram_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rec_req,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_data,
  output logic              o_rec_ack,
  input  logic              i_play_req,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic [DATA_W-1:0] o_play_data,
  output logic              o_play_valid,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_en,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n,
  output logic [1:0]        o_grant,
  output logic              o_busy,
  output logic [1:0]        o_dbg_state
);

  localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_READ    = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // 1: last grant went to the recorder (also marks the current op as a write)
  logic              last_rec_q, last_rec_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_q, dq_d;
  logic [DATA_W-1:0] play_data_q, play_data_d;

  // State and datapath registers; reset drops any transaction in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_rec_q  <= 1'b0;
      addr_q      <= '0;
      dq_q        <= '0;
      play_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_rec_q  <= last_rec_d;
      addr_q      <= addr_d;
      dq_q        <= dq_d;
      play_data_q <= play_data_d;
    end
  end

  // Next-state: round-robin grant in idle, fixed-length access, one recovery cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_rec_d  = last_rec_q;
    addr_d      = addr_q;
    dq_d        = dq_q;
    play_data_d = play_data_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // On a tie the recorder wins only if the player was served last
        if (i_rec_req && (!i_play_req || !last_rec_q)) begin
          state_d    = S_WRITE;
          last_rec_d = 1'b1;
          addr_d     = i_rec_addr;
          dq_d       = i_rec_data;
        end else if (i_play_req) begin
          state_d    = S_READ;
          last_rec_d = 1'b0;
          addr_d     = i_play_addr;
        end
      end
      S_WRITE: begin
        if (cnt_q == CNT_W'(WR_CYCLES - 1)) begin
          state_d = S_RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_READ: begin
        if (cnt_q == CNT_W'(RD_CYCLES - 1)) begin
          state_d     = S_RECOVER;
          cnt_d       = '0;
          play_data_d = i_sram_dq;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RECOVER: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes and status decoded from registered state only (no req-to-output path)
  always_comb begin
    o_sram_ce_n  = (state_q == S_IDLE);
    o_sram_lb_n  = (state_q == S_IDLE);
    o_sram_ub_n  = (state_q == S_IDLE);
    o_sram_we_n  = (state_q != S_WRITE);
    o_sram_oe_n  = (state_q != S_READ);
    // DQ stays driven through recovery after a write for data hold time
    o_sram_dq_en = (state_q == S_WRITE) || ((state_q == S_RECOVER) && last_rec_q);
    o_rec_ack    = (state_q == S_RECOVER) && last_rec_q;
    o_play_valid = (state_q == S_RECOVER) && !last_rec_q;
    o_busy       = (state_q != S_IDLE);
    o_grant      = 2'b00;
    if (state_q != S_IDLE) begin
      o_grant = last_rec_q ? 2'b01 : 2'b10;
    end
    o_sram_addr  = addr_q;
    o_sram_dq    = dq_q;
    o_play_data  = play_data_q;
    o_dbg_state  = state_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed tests on a default-parameter arbiter plus random
// sequential traffic on a WR_CYCLES=1 / RD_CYCLES=3 instance. Drivers push
// expected completions {is_read, addr, data, cycle} into exp_q; per-instance
// monitors pop and compare whenever an ack/valid pulse appears.
module tb_sram_arbiter;

  localparam int W = 69;

  logic clk;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  // ---------------- instance 1: default parameters ----------------
  logic        rst, rec_req, rec_ack, play_req, play_valid;
  logic [19:0] rec_addr, play_addr, sram_addr;
  logic [15:0] rec_data, play_data, sram_dq_o, sram_dq_i;
  logic        dq_en, ce_n, we_n, oe_n, lb_n, ub_n, busy;
  logic [1:0]  grant, dbg_state;

  // ---------------- instance 2: WR_CYCLES=1, RD_CYCLES=3 ----------------
  logic        rst2, rec_req2, rec_ack2, play_req2, play_valid2;
  logic [19:0] rec_addr2, play_addr2, sram_addr2;
  logic [15:0] rec_data2, play_data2, sram_dq_o2, sram_dq_i2;
  logic        dq_en2, ce_n2, we_n2, oe_n2, lb_n2, ub_n2, busy2;
  logic [1:0]  grant2, dbg_state2;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp2_q[$];

  // SRAM models (index by low address byte) and bench-side reference contents
  logic [15:0] mem1 [256] = '{default: 16'h0000};
  logic [15:0] mem2 [256] = '{default: 16'h0000};
  logic [15:0] ref1 [256] = '{default: 16'h0000};
  logic [15:0] ref2 [256] = '{default: 16'h0000};
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  bit          done2 = 1'b0;

  sram_arbiter u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_rec_req(rec_req), .i_rec_addr(rec_addr), .i_rec_data(rec_data), .o_rec_ack(rec_ack),
    .i_play_req(play_req), .i_play_addr(play_addr), .o_play_data(play_data), .o_play_valid(play_valid),
    .o_sram_addr(sram_addr), .o_sram_dq(sram_dq_o), .o_sram_dq_en(dq_en), .i_sram_dq(sram_dq_i),
    .o_sram_ce_n(ce_n), .o_sram_we_n(we_n), .o_sram_oe_n(oe_n), .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n),
    .o_grant(grant), .o_busy(busy), .o_dbg_state(dbg_state)
  );

  sram_arbiter #(.WR_CYCLES(1), .RD_CYCLES(3)) u_dut2 (
    .i_clk(clk), .i_rst(rst2),
    .i_rec_req(rec_req2), .i_rec_addr(rec_addr2), .i_rec_data(rec_data2), .o_rec_ack(rec_ack2),
    .i_play_req(play_req2), .i_play_addr(play_addr2), .o_play_data(play_data2), .o_play_valid(play_valid2),
    .o_sram_addr(sram_addr2), .o_sram_dq(sram_dq_o2), .o_sram_dq_en(dq_en2), .i_sram_dq(sram_dq_i2),
    .o_sram_ce_n(ce_n2), .o_sram_we_n(we_n2), .o_sram_oe_n(oe_n2), .o_sram_lb_n(lb_n2), .o_sram_ub_n(ub_n2),
    .o_grant(grant2), .o_busy(busy2), .o_dbg_state(dbg_state2)
  );

  // ---------------- clock / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SRAM models ----------------
  always @(posedge clk) begin
    if (load_en) mem1[load_addr] <= load_data;
    else if (!ce_n && !we_n) mem1[sram_addr[7:0]] <= sram_dq_o;
  end

  always @(posedge clk) begin
    if (!ce_n2 && !we_n2) mem2[sram_addr2[7:0]] <= sram_dq_o2;
  end

  // Garbage while OE_N is high so a mistimed capture shows up
  assign sram_dq_i  = oe_n  ? 16'hDEAD : mem1[sram_addr[7:0]];
  assign sram_dq_i2 = oe_n2 ? 16'hDEAD : mem2[sram_addr2[7:0]];

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event not expected/seen (cycle %0d)", name, cyc);
  endtask

  task automatic score(input string tag, input logic [W-1:0] e, input logic ack, input logic vld,
                       input logic [19:0] addr, input logic [15:0] pdata, input logic [15:0] mword,
                       input logic [1:0] g);
    logic [15:0] act;
    act = e[68] ? pdata : mword;
    check({tag, "_kind"},  64'(vld), 64'(e[68]));
    check({tag, "_excl"},  64'(ack & vld), 64'(0));
    check({tag, "_addr"},  64'(addr), 64'(e[67:48]));
    check({tag, "_data"},  64'(act), 64'(e[47:32]));
    check({tag, "_cycle"}, 64'(cyc), 64'(e[31:0]));
    check({tag, "_grant"}, 64'(g), e[68] ? 64'(2) : 64'(1));
  endtask

  task automatic invariants(input string tag, input logic we, input logic oe, input logic en);
    check({tag, "_we_oe_overlap"}, 64'(we | oe), 64'(1));
    if (!oe) check({tag, "_dq_en_in_read"}, 64'(en), 64'(0));
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst) begin
      invariants("d1", we_n, oe_n, dq_en);
      if (rec_ack || play_valid) begin
        if (exp_q.size() == 0) fail_now("d1_unexpected_resp");
        else score("d1", exp_q.pop_front(), rec_ack, play_valid, sram_addr, play_data,
                   mem1[sram_addr[7:0]], grant);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst2) begin
      invariants("d2", we_n2, oe_n2, dq_en2);
      if (rec_ack2 || play_valid2) begin
        if (exp2_q.size() == 0) fail_now("d2_unexpected_resp");
        else score("d2", exp2_q.pop_front(), rec_ack2, play_valid2, sram_addr2, play_data2,
                   mem2[sram_addr2[7:0]], grant2);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic load1(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = a; load_data = d;
    ref1[a] = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic push1(input logic rd, input logic [19:0] a, input logic [15:0] d, input int c);
    exp_q.push_back({rd, a, d, 32'(c)});
  endtask

  // Directed tests on instance 1
  initial begin
    int t0;
    rst = 1'b1; rec_req = 1'b0; play_req = 1'b0;
    rec_addr = '0; rec_data = '0; play_addr = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_strobes_n", 64'({ce_n, we_n, oe_n, lb_n, ub_n}), 64'(5'b11111));
    check("rst_dq_en",     64'(dq_en), 64'(0));
    check("rst_addr",      64'(sram_addr), 64'(0));
    check("rst_dq",        64'(sram_dq_o), 64'(0));
    check("rst_play_data", 64'(play_data), 64'(0));
    check("rst_pulses",    64'({rec_ack, play_valid}), 64'(0));
    check("rst_grant",     64'(grant), 64'(0));
    check("rst_busy",      64'(busy), 64'(0));

    // Single write: 0x00005 <= 0xA5A5, ack in cycle 3
    @(posedge clk); #1;
    t0 = cyc;
    rec_req = 1'b1; rec_addr = 20'h00005; rec_data = 16'hA5A5;
    ref1[8'h05] = 16'hA5A5;
    push1(1'b0, 20'h00005, 16'hA5A5, t0 + 3);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check("wr_we_n", 64'(we_n), 64'(!(k == 1 || k == 2)));
      check("wr_dq_en", 64'(dq_en), 64'(k >= 1 && k <= 3));
    end
    rec_req = 1'b0;

    // Single read from top address: valid in cycle 3, data held afterwards
    load1(8'hFF, 16'h1234);
    @(posedge clk); #1;
    t0 = cyc;
    play_req = 1'b1; play_addr = 20'hFFFFF;
    push1(1'b1, 20'hFFFFF, 16'h1234, t0 + 3);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check("rd_oe_n", 64'(oe_n), 64'(!(k == 1 || k == 2)));
      check("rd_dq_en", 64'(dq_en), 64'(0));
    end
    play_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rd_data_hold", 64'(play_data), 64'(16'h1234));

    // Fresh reset so the first tie goes to the recorder
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Both held: rec, play, rec, play, 4 cycles apart
    @(posedge clk); #1;
    t0 = cyc;
    rec_req = 1'b1; rec_addr = 20'h00011; rec_data = 16'h1111;
    play_req = 1'b1; play_addr = 20'h00005;
    ref1[8'h11] = 16'h1111;
    push1(1'b0, 20'h00011, 16'h1111, t0 + 3);
    push1(1'b1, 20'h00005, 16'hA5A5, t0 + 7);
    ref1[8'h12] = 16'h2222;
    push1(1'b0, 20'h00012, 16'h2222, t0 + 11);
    push1(1'b1, 20'h00011, 16'h1111, t0 + 15);
    repeat (4) @(posedge clk); #1;
    rec_addr = 20'h00012; rec_data = 16'h2222;
    repeat (4) @(posedge clk); #1;
    play_addr = 20'h00011;
    repeat (4) @(posedge clk); #1;
    rec_req = 1'b0;
    repeat (4) @(posedge clk); #1;
    play_req = 1'b0;

    // Read request raised mid-write waits for idle; valid in cycle 7
    @(posedge clk); #1;
    t0 = cyc;
    rec_req = 1'b1; rec_addr = 20'h00030; rec_data = 16'hBEEF;
    ref1[8'h30] = 16'hBEEF;
    push1(1'b0, 20'h00030, 16'hBEEF, t0 + 3);
    repeat (2) @(posedge clk); #1;
    play_req = 1'b1; play_addr = 20'h00030;
    push1(1'b1, 20'h00030, 16'hBEEF, t0 + 7);
    @(negedge clk);
    check("mid_grant_c2", 64'(grant), 64'(1));
    repeat (2) @(posedge clk); #1;
    rec_req = 1'b0;
    @(negedge clk);
    check("mid_grant_c4", 64'(grant), 64'(0));
    repeat (4) @(posedge clk); #1;
    play_req = 1'b0;

    // Reset in write cycle 1: strobes high in cycle 2, then regrant
    @(posedge clk); #1;
    t0 = cyc;
    rec_req = 1'b1; rec_addr = 20'h00040; rec_data = 16'h7777;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_strobes_n", 64'({ce_n, we_n, oe_n, lb_n, ub_n}), 64'(5'b11111));
    check("rstmid_dq_en", 64'(dq_en), 64'(0));
    check("rstmid_ack", 64'(rec_ack), 64'(0));
    check("rstmid_busy", 64'(busy), 64'(0));
    ref1[8'h40] = 16'h7777;
    push1(1'b0, 20'h00040, 16'h7777, t0 + 5);
    repeat (4) @(posedge clk); #1;
    rec_req = 1'b0;

    // Wait for the second instance's random traffic, bounded
    for (int k = 0; k < 3000 && !done2; k++) @(posedge clk);
    if (!done2) fail_now("d2_traffic_timeout");
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("d1_queue_drained", 64'(exp_q.size()), 64'(0));
    check("d2_queue_drained", 64'(exp2_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Random sequential traffic on instance 2: write ack in cycle 2, read valid in cycle 4
  initial begin
    int          t0;
    int          gap;
    bit          rd;
    bit          seen;
    logic [19:0] a;
    logic [15:0] d;
    rst2 = 1'b1; rec_req2 = 1'b0; play_req2 = 1'b0;
    rec_addr2 = '0; rec_data2 = '0; play_addr2 = '0;
    repeat (3) @(posedge clk);
    #1 rst2 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 2);
      rd  = 1'($urandom_range(0, 1));
      a   = 20'($urandom_range(0, 7));
      d   = 16'($urandom);
      repeat (gap) @(posedge clk);
      @(posedge clk); #1;
      t0 = cyc;
      if (rd) begin
        play_req2 = 1'b1; play_addr2 = a;
        exp2_q.push_back({1'b1, a, ref2[a[7:0]], 32'(t0 + 4)});
      end else begin
        rec_req2 = 1'b1; rec_addr2 = a; rec_data2 = d;
        ref2[a[7:0]] = d;
        exp2_q.push_back({1'b0, a, d, 32'(t0 + 2)});
      end
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (rec_ack2 || play_valid2) seen = 1'b1;
      end
      if (!seen) fail_now("d2_resp_timeout");
      rec_req2 = 1'b0;
      play_req2 = 1'b0;
    end
    done2 = 1'b1;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-port SRAM access controller sharing the external 1M×16 SRAM between the recorder write stream and the player read stream. Sits between the recorder/player blocks and the SRAM pins in the top level, turning word-level request/acknowledge handshakes into correctly sequenced SRAM strobe cycles. Contention is resolved round-robin, so neither stream starves.

## Interface
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, SRAM data width
- WR_CYCLES, 2, cycles WE_N is held low per write (≥1)
- RD_CYCLES, 2, cycles OE_N is held low per read before data capture (≥1)

- i_clk  in  1  single clock for the whole block
- i_rst  in  1  reset, synchronous, active-high
- i_rec_req  in  1  recorder write request (level)
- i_rec_addr  in  ADDR_W  write address, stable while i_rec_req high
- i_rec_data  in  DATA_W  write data, stable while i_rec_req high
- o_rec_ack  out  1  one-cycle pulse, write completed
- i_play_req  in  1  player read request (level)
- i_play_addr  in  ADDR_W  read address, stable while i_play_req high
- o_play_data  out  DATA_W  read data, held until next read completes
- o_play_valid  out  1  one-cycle pulse, o_play_data updated
- o_sram_addr  out  ADDR_W  SRAM address
- o_sram_dq  out  DATA_W  SRAM write data
- o_sram_dq_en  out  1  tri-state enable for DQ (top drives inout)
- i_sram_dq  in  DATA_W  SRAM DQ readback
- o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes, active-low
- o_grant  out  2  current owner: 2'b01 recorder, 2'b10 player, 2'b00 none
- o_busy  out  1  high in any state but S_IDLE

## Operation
- FSM states: S_IDLE, S_WRITE, S_READ, S_RECOVER. Access counter width ≥ clog2(max(WR_CYCLES, RD_CYCLES)+1).
- S_IDLE: all strobes high, dq_en 0, o_grant 00. Requests are sampled here. Only rec → S_WRITE. Only play → S_READ. Both → the requester not served last. A winner's addr/data are latched into internal registers at the transition.
- last_grant register: resets to "player", so the recorder wins the first tie. It updates on every grant.
- S_WRITE: ce_n, lb_n, ub_n, we_n = 0; dq_en = 1; o_sram_dq = latched data. Lasts exactly WR_CYCLES cycles, then → S_RECOVER.
- S_READ: ce_n, lb_n, ub_n, oe_n = 0; dq_en = 0. Lasts RD_CYCLES cycles. i_sram_dq is captured into o_play_data on the clock edge ending the last S_READ cycle, then → S_RECOVER.
- S_RECOVER: one cycle. we_n and oe_n = 1. ce_n stays 0. o_sram_addr holds. After a write, dq_en and dq hold for data hold time. o_rec_ack or o_play_valid is 1 here, matching the transaction. Then → S_IDLE unconditionally.
- o_sram_addr and o_sram_dq change only on S_IDLE→access transitions. They hold their last values while idle.
- Requester rule: deassert req in the cycle after ack/valid. A req still high in S_IDLE after that is treated as a new request.
- Fairness: the maximum wait for a held request is one foreign transaction.
- A request raised during a transaction is not sampled until S_IDLE.
- Synchronous reset, mid-transaction included: next state S_IDLE. The pending transaction is dropped with no ack/valid, and strobes deassert on the reset edge.

## Timing
- Reset values: ce_n/we_n/oe_n/lb_n/ub_n = 1, dq_en = 0, o_sram_addr = 0, o_sram_dq = 0, o_play_data = 0, o_rec_ack = 0, o_play_valid = 0, o_grant = 00, o_busy = 0.
- All outputs are registered or decoded from state registers only; there is no combinational path from request inputs to outputs.
- Write timeline: req seen high in S_IDLE at cycle 0. Cycles 1..WR_CYCLES are S_WRITE. Cycle WR_CYCLES+1 is S_RECOVER with o_rec_ack = 1. With defaults, ack is in cycle 3.
- Read timeline: cycles 1..RD_CYCLES are S_READ, with data captured at the end of cycle RD_CYCLES. o_play_valid is in cycle RD_CYCLES+1 (cycle 3 by default).
- Transaction period is access cycles + 2. Back-to-back throughput is one word per 4 cycles at defaults.

## Test plan
- Reset then single write: rec_req with addr 0x00005, data 0xA5A5 → we_n low in cycles 1–2, dq_en 1 in cycles 1–3, o_rec_ack pulse in cycle 3 only, model SRAM[5] = 0xA5A5.
- Single read: model SRAM[0xFFFFF] = 0x1234, play_req with addr 0xFFFFF → oe_n low in cycles 1–2, o_play_valid in cycle 3, o_play_data = 0x1234 held afterwards, dq_en never 1.
- Simultaneous requests held continuously → grants alternate rec, play, rec, play, starting with rec after reset. Each ack/valid is 4 cycles apart, and o_grant matches.
- Request during transaction: play_req rises in cycle 2 of a write → not granted until the S_IDLE in cycle 4. Read valid in cycle 7. No strobe overlap, and we_n and oe_n are never both 0.
- Reset asserted in cycle 1 of S_WRITE → cycle 2 has all strobes high, dq_en 0, no o_rec_ack. After reset the held rec_req is regranted and completes normally.
- Parameter sweep WR_CYCLES = 1, RD_CYCLES = 3 → ack in cycle 2, valid in cycle 4; random traffic vs a reference SRAM model shows zero data mismatches.
